video_pattern_gen: RTL and testbench

- AXI4-Stream video master that generates synthetic frames for the scanout stage's video input (tdata/tlast/tuser/tvalid, tready).
- Replaces the VDMA during bring-up and lets the team isolate line-fetch and scanout faults from DDR and VDMA faults.
- Emits frames with the same framing the scanout stage expects: tuser[0] on the first word of each frame, tlast on the last word of each line.
- Pixel packing follows the codebase colour modes (8/16/32-bit per pixel, packed into 32-bit words).

---
 rtl/video_pattern_gen_if.sv | 11 +
 rtl/video_pattern_gen.sv | 223 ++++++++++++++++++++++
 tb/tb_video_pattern_gen.sv | 365 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/video_pattern_gen_if.sv
// AXI4-Stream video bus between the pattern generator and the scanout stage.
interface video_pattern_gen_if;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tlast;
  logic        tuser;

  modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/video_pattern_gen.sv
// Synthetic AXI4-Stream frame source: solid/ramp/bars/checker patterns in
// 8/16/32-bit colour modes, framed with tuser (frame start) and tlast (line end).
module video_pattern_gen #(
  parameter int MAX_W     = 1280,
  parameter int MAX_H     = 1024,
  parameter int FRAME_GAP = 16
) (
  input  logic                       m_axis_vid_aclk,
  input  logic                       aresetn,
  input  logic                       cfg_enable,
  input  logic [11:0]                cfg_width,
  input  logic [11:0]                cfg_height,
  input  logic [2:0]                 cfg_colormode,
  input  logic [1:0]                 cfg_pattern,
  input  logic [31:0]                cfg_color,
  video_pattern_gen_if.master        m_axis_vid,
  output logic [15:0]                frame_count,
  output logic                       cfg_error
);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_GAP} state_e;
  typedef enum logic [1:0] {MODE8, MODE16, MODE32} mode_e;

  // The IDLE decision cycle is itself idle, so GAP lasts one cycle less.
  localparam int unsigned GAP_LAST = (FRAME_GAP > 1) ? FRAME_GAP - 2 : 0;

  state_e      state_q, state_nxt;
  mode_e       mode_q, mode_nxt, mode_in;
  logic [1:0]  pat_q, pat_nxt;
  logic [31:0] color_q, color_nxt;
  logic [11:0] w_q, w_nxt, w_in;
  logic [11:0] h_q, h_nxt, h_in;
  logic [11:0] wpl_q, wpl_nxt, wpl_in;
  logic [11:0] x_q, x_nxt, y_q, y_nxt;
  logic [15:0] gap_q, gap_nxt;
  logic [15:0] fcnt_q, fcnt_nxt;
  logic [31:0] tdata_q, tdata_nxt;
  logic        tvalid_q, tvalid_nxt, tlast_q, tlast_nxt, tuser_q, tuser_nxt;
  logic        err_q, err_nxt, load_word;

  function automatic logic [31:0] make_word(input logic [11:0] xi, input logic [11:0] yi,
                                            input mode_e m, input logic [1:0] pat,
                                            input logic [31:0] color, input logic [11:0] w);
    logic [31:0] word;
    logic [13:0] p;
    logic [2:0]  b;
    logic        on;
    word = '0;
    case (m)
      MODE8: begin
        for (int unsigned k = 0; k < 4; k++) begin
          p  = {xi, 2'b00} + 14'(k);
          b  = p[8:6];
          on = p[4] ^ yi[4];
          if (p < {2'b00, w}) begin
            case (pat)
              2'd0:    word[8*k +: 8] = color[8*k +: 8];
              2'd1:    word[8*k +: 8] = p[7:0];
              2'd2:    word[8*k +: 8] = {5'b0, b};
              default: word[8*k +: 8] = {8{on}};
            endcase
          end
        end
      end
      MODE16: begin
        for (int unsigned k = 0; k < 2; k++) begin
          p  = {1'b0, xi, 1'b0} + 14'(k);
          b  = p[8:6];
          on = p[4] ^ yi[4];
          if (p < {2'b00, w}) begin
            case (pat)
              2'd0:    word[16*k +: 16] = color[16*k +: 16];
              2'd1:    word[16*k +: 16] = {p[4:0], p[5:0], p[4:0]};
              2'd2:    word[16*k +: 16] = {{5{b[2]}}, {6{b[1]}}, {5{b[0]}}};
              default: word[16*k +: 16] = {16{on}};
            endcase
          end
        end
      end
      default: begin
        p  = {2'b00, xi};
        b  = p[8:6];
        on = p[4] ^ yi[4];
        case (pat)
          2'd0:    word = color;
          2'd1:    word = {8'h00, p[7:0], p[7:0], p[7:0]};
          2'd2:    word = {8'h00, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
          default: word = {32{on}};
        endcase
      end
    endcase
    return word;
  endfunction

  always_comb begin
    w_in    = (cfg_width  > 12'(MAX_W)) ? 12'(MAX_W) : cfg_width;
    h_in    = (cfg_height > 12'(MAX_H)) ? 12'(MAX_H) : cfg_height;
    mode_in = (cfg_colormode == 3'd0) ? MODE8 : (cfg_colormode == 3'd1) ? MODE16 : MODE32;
    case (mode_in)
      MODE8:   wpl_in = 12'(({1'b0, w_in} + 13'd3) >> 2);
      MODE16:  wpl_in = 12'(({1'b0, w_in} + 13'd1) >> 1);
      default: wpl_in = w_in;
    endcase
  end

  always_comb begin
    state_nxt  = state_q;
    mode_nxt   = mode_q;
    pat_nxt    = pat_q;
    color_nxt  = color_q;
    w_nxt      = w_q;
    h_nxt      = h_q;
    wpl_nxt    = wpl_q;
    x_nxt      = x_q;
    y_nxt      = y_q;
    gap_nxt    = gap_q;
    fcnt_nxt   = fcnt_q;
    tdata_nxt  = tdata_q;
    tvalid_nxt = tvalid_q;
    tlast_nxt  = tlast_q;
    tuser_nxt  = tuser_q;
    err_nxt    = 1'b0;
    load_word  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cfg_enable) begin
          if (wpl_in != '0 && h_in != '0) begin
            mode_nxt   = mode_in;
            pat_nxt    = cfg_pattern;
            color_nxt  = cfg_color;
            w_nxt      = w_in;
            h_nxt      = h_in;
            wpl_nxt    = wpl_in;
            x_nxt      = '0;
            y_nxt      = '0;
            state_nxt  = S_ACTIVE;
            tvalid_nxt = 1'b1;
            tuser_nxt  = 1'b1;
            tlast_nxt  = (wpl_in == 12'd1);
            load_word  = 1'b1;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      S_ACTIVE: begin
        if (m_axis_vid.tready) begin
          tuser_nxt = 1'b0;
          if (tlast_q && y_q == h_q - 12'd1) begin
            fcnt_nxt   = fcnt_q + 16'd1;
            tvalid_nxt = 1'b0;
            tlast_nxt  = 1'b0;
            tdata_nxt  = '0;
            gap_nxt    = '0;
            state_nxt  = (FRAME_GAP > 1) ? S_GAP : S_IDLE;
          end else if (tlast_q) begin
            x_nxt     = '0;
            y_nxt     = y_q + 12'd1;
            tlast_nxt = (wpl_q == 12'd1);
            load_word = 1'b1;
          end else begin
            x_nxt     = x_q + 12'd1;
            tlast_nxt = (x_q + 12'd1 == wpl_q - 12'd1);
            load_word = 1'b1;
          end
        end
      end
      S_GAP: begin
        if (gap_q == 16'(GAP_LAST)) state_nxt = S_IDLE;
        else                        gap_nxt   = gap_q + 16'd1;
      end
      default: state_nxt = S_IDLE;
    endcase
    // Next word is built from the next position and the config in force for it.
    if (load_word) tdata_nxt = make_word(x_nxt, y_nxt, mode_nxt, pat_nxt, color_nxt, w_nxt);
  end

  always_ff @(posedge m_axis_vid_aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= S_IDLE;
      mode_q   <= MODE32;
      pat_q    <= '0;
      color_q  <= '0;
      w_q      <= '0;
      h_q      <= '0;
      wpl_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      gap_q    <= '0;
      fcnt_q   <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tuser_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      mode_q   <= mode_nxt;
      pat_q    <= pat_nxt;
      color_q  <= color_nxt;
      w_q      <= w_nxt;
      h_q      <= h_nxt;
      wpl_q    <= wpl_nxt;
      x_q      <= x_nxt;
      y_q      <= y_nxt;
      gap_q    <= gap_nxt;
      fcnt_q   <= fcnt_nxt;
      tdata_q  <= tdata_nxt;
      tvalid_q <= tvalid_nxt;
      tlast_q  <= tlast_nxt;
      tuser_q  <= tuser_nxt;
      err_q    <= err_nxt;
    end
  end

  assign m_axis_vid.tdata  = tdata_q;
  assign m_axis_vid.tvalid = tvalid_q;
  assign m_axis_vid.tlast  = tlast_q;
  assign m_axis_vid.tuser  = tuser_q;
  assign frame_count       = fcnt_q;
  assign cfg_error         = err_q;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Bench for video_pattern_gen: expected frames come from a pixel-level model
// packed into words; transfers are checked word by word under random backpressure.
module tb_video_pattern_gen;
  localparam int MAX_W     = 1280;
  localparam int MAX_H     = 1024;
  localparam int FRAME_GAP = 16;

  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic        cfg_enable = 1'b0;
  logic [11:0] cfg_width = '0;
  logic [11:0] cfg_height = '0;
  logic [2:0]  cfg_colormode = '0;
  logic [1:0]  cfg_pattern = '0;
  logic [31:0] cfg_color = '0;
  logic [15:0] frame_count;
  logic        cfg_error;

  video_pattern_gen_if vif ();

  video_pattern_gen #(.MAX_W(MAX_W), .MAX_H(MAX_H), .FRAME_GAP(FRAME_GAP)) dut (
    .m_axis_vid_aclk (clk),
    .aresetn         (aresetn),
    .cfg_enable      (cfg_enable),
    .cfg_width       (cfg_width),
    .cfg_height      (cfg_height),
    .cfg_colormode   (cfg_colormode),
    .cfg_pattern     (cfg_pattern),
    .cfg_color       (cfg_color),
    .m_axis_vid      (vif),
    .frame_count     (frame_count),
    .cfg_error       (cfg_error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic        l;
    logic        u;
  } beat_t;

  beat_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  int mid_at = -1;
  int mid_action = 0;
  int mid_width = 0;

  function automatic int unsigned pix(input int unsigned p, input int unsigned y,
                                      input int unsigned bits, input int unsigned pat,
                                      input logic [31:0] color, input int unsigned k);
    int unsigned mask, b, on, v;
    mask = (bits == 32) ? 32'hFFFF_FFFF : ((32'd1 << bits) - 1);
    b    = (p / 64) % 8;
    on   = ((p / 16) % 2) ^ ((y / 16) % 2);
    case (pat)
      0: return (color >> (k * bits)) & mask;
      1: begin
        if (bits == 8)  return p % 256;
        if (bits == 16) return ((p % 32) << 11) | ((p % 64) << 5) | (p % 32);
        v = p % 256;
        return (v << 16) | (v << 8) | v;
      end
      2: begin
        if (bits == 8) return b;
        if (bits == 16)
          return (((b & 4) != 0) ? (31 << 11) : 0) | (((b & 2) != 0) ? (63 << 5) : 0) |
                 (((b & 1) != 0) ? 31 : 0);
        return (((b & 4) != 0) ? 32'hFF0000 : 0) | (((b & 2) != 0) ? 32'h00FF00 : 0) |
               (((b & 1) != 0) ? 32'h0000FF : 0);
      end
      default: return (on != 0) ? mask : 0;
    endcase
  endfunction

  task automatic build_frame(input int unsigned w, input int unsigned h, input int unsigned cm,
                             input int unsigned pat, input logic [31:0] color);
    int unsigned wc, hc, bits, ppw, wpl, p;
    logic [31:0] word;
    beat_t bt;
    wc   = (w > MAX_W) ? MAX_W : w;
    hc   = (h > MAX_H) ? MAX_H : h;
    bits = (cm == 0) ? 8 : (cm == 1) ? 16 : 32;
    ppw  = 32 / bits;
    wpl  = (wc + ppw - 1) / ppw;
    exp_q.delete();
    for (int unsigned y = 0; y < hc; y++) begin
      for (int unsigned x = 0; x < wpl; x++) begin
        word = '0;
        for (int unsigned k = 0; k < ppw; k++) begin
          p = x * ppw + k;
          if (p < wc) word = word | (pix(p, y, bits, pat, color, k) << (k * bits));
        end
        bt.d = word;
        bt.l = (x == wpl - 1);
        bt.u = (x == 0 && y == 0);
        exp_q.push_back(bt);
      end
    end
  endtask

  task automatic set_cfg(input int unsigned w, input int unsigned h, input int unsigned cm,
                         input int unsigned pat, input logic [31:0] color);
    cfg_width     = 12'(w);
    cfg_height    = 12'(h);
    cfg_colormode = 3'(cm);
    cfg_pattern   = 2'(pat);
    cfg_color     = color;
  endtask

  task automatic do_reset();
    cfg_enable = 1'b0;
    vif.tready = 1'b1;
    aresetn    = 1'b0;
    repeat (3) @(negedge clk);
    aresetn = 1'b1;
    @(negedge clk);
  endtask

  // Consumes exp_q.size() transfers; bp is the percentage of cycles with tready low.
  task automatic check_frame(input string name, input int bp);
    int    idx, cyc, budget;
    logic  stalled, started;
    beat_t prev, e;
    idx = 0; cyc = 0; stalled = 1'b0; started = 1'b0; prev = '0;
    budget = exp_q.size() * 4 + 200;
    while (idx < exp_q.size() && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (stalled) begin
        vectors++;
        if (vif.tvalid !== 1'b1 || vif.tdata !== prev.d || vif.tlast !== prev.l ||
            vif.tuser !== prev.u) begin
          miscompares++;
          $display("FAIL %s stall_hold word %0d got v%b %h l%b u%b want v1 %h l%b u%b", name,
                   idx, vif.tvalid, vif.tdata, vif.tlast, vif.tuser, prev.d, prev.l, prev.u);
        end
      end else if (started) begin
        vectors++;
        if (vif.tvalid !== 1'b1) begin
          miscompares++;
          $display("FAIL %s tvalid_gap word %0d got %b want 1", name, idx, vif.tvalid);
        end
      end
      vif.tready = ($urandom_range(99) >= bp);
      if (vif.tvalid === 1'b1 && vif.tready) begin
        e = exp_q[idx];
        vectors++;
        if (vif.tdata !== e.d || vif.tlast !== e.l || vif.tuser !== e.u) begin
          miscompares++;
          $display("FAIL %s word %0d got %h l%b u%b want %h l%b u%b", name, idx, vif.tdata,
                   vif.tlast, vif.tuser, e.d, e.l, e.u);
        end
        started = 1'b1;
        if (idx == mid_at) begin
          if (mid_action == 1) cfg_enable = 1'b0;
          else                 cfg_width  = 12'(mid_width);
        end
        idx++;
      end
      stalled = (vif.tvalid === 1'b1) && !vif.tready;
      prev.d = vif.tdata; prev.l = vif.tlast; prev.u = vif.tuser;
    end
    vif.tready = 1'b1;
    mid_at = -1;
    if (idx < exp_q.size()) begin
      vectors++;
      miscompares++;
      $display("FAIL %s timeout got %0d words want %0d", name, idx, exp_q.size());
    end
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    vif.tready = 1'b1;
    #1;
    vectors++;
    if (vif.tvalid !== 1'b0 || vif.tlast !== 1'b0 || vif.tuser !== 1'b0 ||
        vif.tdata !== 32'h0 || frame_count !== 16'h0 || cfg_error !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state got v%b l%b u%b d%h fc%0d e%b want all zero", vif.tvalid,
               vif.tlast, vif.tuser, vif.tdata, frame_count, cfg_error);
    end
    do_reset();
  endtask

  task automatic test_framing();
    int n;
    do_reset();
    set_cfg(8, 2, 2, 0, 32'h0011_2233);
    build_frame(8, 2, 2, 0, 32'h0011_2233);
    cfg_enable = 1'b1;
    check_frame("framing", 0);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i == 0) begin
        vectors++;
        if (frame_count !== 16'd1) begin
          miscompares++;
          $display("FAIL frame_count got %0d want 1", frame_count);
        end
      end
      if (vif.tvalid === 1'b1) break;
      n++;
    end
    vectors++;
    if (n != FRAME_GAP || vif.tuser !== 1'b1) begin
      miscompares++;
      $display("FAIL frame_gap got %0d idle cycles tuser %b want %0d tuser 1", n, vif.tuser,
               FRAME_GAP);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    set_cfg(8, 2, 2, 0, 32'h0011_2233);
    build_frame(8, 2, 2, 0, 32'h0011_2233);
    cfg_enable = 1'b1;
    check_frame("backpressure_f0", 50);
    check_frame("backpressure_f1", 50);
  endtask

  task automatic test_ramp8();
    beat_t bt;
    do_reset();
    set_cfg(6, 1, 0, 1, 32'h0);
    exp_q.delete();
    bt.d = 32'h0302_0100; bt.l = 1'b0; bt.u = 1'b1; exp_q.push_back(bt);
    bt.d = 32'h0000_0504; bt.l = 1'b1; bt.u = 1'b0; exp_q.push_back(bt);
    cfg_enable = 1'b1;
    check_frame("ramp8", 0);
  endtask

  task automatic test_single_word();
    do_reset();
    set_cfg(1, 1, 2, 1, 32'h0);
    build_frame(1, 1, 2, 1, 32'h0);
    cfg_enable = 1'b1;
    check_frame("single_word", 20);
  endtask

  task automatic test_checker();
    do_reset();
    set_cfg(40, 20, 1, 3, 32'h0);
    build_frame(40, 20, 1, 3, 32'h0);
    cfg_enable = 1'b1;
    check_frame("checker16", 30);
  endtask

  task automatic test_random();
    int unsigned w, h, cm, pat;
    logic [31:0] color;
    for (int i = 0; i < 6; i++) begin
      w = $urandom_range(1, 600); h = $urandom_range(1, 3);
      cm = $urandom_range(0, 7); pat = $urandom_range(0, 3); color = $urandom;
      do_reset();
      set_cfg(w, h, cm, pat, color);
      build_frame(w, h, cm, pat, color);
      cfg_enable = 1'b1;
      check_frame($sformatf("random%0d_w%0d_h%0d_m%0d_p%0d", i, w, h, cm, pat), 50);
    end
  endtask

  task automatic test_cfg_error();
    logic seen;
    do_reset();
    set_cfg(0, 4, 2, 0, 32'h1);
    cfg_enable = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (vif.tvalid === 1'b1) seen = 1'b1;
    end
    vectors++;
    if (cfg_error !== 1'b1 || seen) begin
      miscompares++;
      $display("FAIL cfg_error_zero got err %b tvalid_seen %b want err 1 tvalid_seen 0",
               cfg_error, seen);
    end
    cfg_enable = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (cfg_error !== 1'b0) begin
      miscompares++;
      $display("FAIL cfg_error_clear got %b want 0", cfg_error);
    end
    set_cfg(2000, 1, 2, 1, 32'h0);
    build_frame(2000, 1, 2, 1, 32'h0);
    cfg_enable = 1'b1;
    check_frame("clamp_width", 10);
  endtask

  task automatic test_mid_enable_drop();
    logic seen;
    do_reset();
    set_cfg(8, 4, 2, 2, 32'h0);
    build_frame(8, 4, 2, 2, 32'h0);
    cfg_enable = 1'b1;
    mid_at = 8; mid_action = 1;
    check_frame("mid_enable_drop", 30);
    seen = 1'b0;
    repeat (FRAME_GAP + 20) begin
      @(negedge clk);
      if (vif.tvalid === 1'b1) seen = 1'b1;
    end
    vectors++;
    if (seen || frame_count !== 16'd1) begin
      miscompares++;
      $display("FAIL enable_drop_stop got tvalid_seen %b fc %0d want 0 fc 1", seen, frame_count);
    end
  endtask

  task automatic test_mid_width_change();
    do_reset();
    set_cfg(8, 4, 2, 1, 32'h0);
    build_frame(8, 4, 2, 1, 32'h0);
    cfg_enable = 1'b1;
    mid_at = 8; mid_action = 2; mid_width = 5;
    check_frame("mid_width_old", 30);
    build_frame(5, 4, 2, 1, 32'h0);
    check_frame("mid_width_new", 30);
  endtask

  task automatic test_reset_mid();
    int cnt;
    do_reset();
    set_cfg(8, 2, 2, 1, 32'h0);
    cfg_enable = 1'b1;
    cnt = 0;
    for (int i = 0; i < 100 && cnt < 5; i++) begin
      @(negedge clk);
      if (vif.tvalid === 1'b1) cnt++;
    end
    aresetn = 1'b0;
    #1;
    vectors++;
    if (vif.tvalid !== 1'b0 || cnt != 5) begin
      miscompares++;
      $display("FAIL reset_mid_async got tvalid %b words %0d want 0 words 5", vif.tvalid, cnt);
    end
    @(negedge clk);
    aresetn = 1'b1;
    build_frame(8, 2, 2, 1, 32'h0);
    check_frame("reset_mid_restart", 0);
  endtask

  initial begin
    vif.tready = 1'b1;
    test_reset();
    test_framing();
    test_backpressure();
    test_ramp8();
    test_single_word();
    test_checker();
    test_random();
    test_cfg_error();
    test_mid_enable_drop();
    test_mid_width_change();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
